// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive controller and its sampler.
// Edge indices refer to positions within one 8-clock bit period.
package uart_rx_pkg;

    localparam int PRESCALE   = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [2:0] SAMPLE_EDGE_A = 3'd3;
    localparam logic [2:0] SAMPLE_EDGE_B = 3'd4;
    localparam logic [2:0] SAMPLE_EDGE_C = 3'd5;
    localparam logic [2:0] CAPTURE_EDGE  = 3'd6;
    localparam logic [2:0] DECIDE_EDGE   = 3'd7;

    localparam logic [3:0] START_BIT      = 4'd0;
    localparam logic [3:0] FIRST_DATA_BIT = 4'd1;
    localparam logic [3:0] LAST_DATA_BIT  = 4'd8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-tap oversample capture with majority vote; the voted bit updates
// on the third sample edge and holds until the next bit's third sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic [2:0] edge_cnt,
    output logic       sampled_bit
);

    logic s3_q, s3_d;
    logic s4_q, s4_d;
    logic bit_q, bit_d;

    always_comb begin
        s3_d  = s3_q;
        s4_d  = s4_q;
        bit_d = bit_q;
        if (edge_cnt == SAMPLE_EDGE_A) begin
            s3_d = RX_IN;
        end else if (edge_cnt == SAMPLE_EDGE_B) begin
            s4_d = RX_IN;
        end else if (edge_cnt == SAMPLE_EDGE_C) begin
            // Third tap is taken live rather than stored separately.
            bit_d = majority3(s3_q, s4_q, RX_IN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_q  <= 1'b0;
            s4_q  <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            s3_q  <= s3_d;
            s4_q  <= s4_d;
            bit_q <= bit_d;
        end
    end

    assign sampled_bit = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control: start detect, edge/bit counters, frame FSM and the
// parity/stop checks against the deserializer's assembled byte.
module uart_rx_ctrl
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    output logic [2:0]            edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  sampled_bit,
    output logic                  deser_en,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_e  state_q, state_d;
    logic [2:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       par_err_q, par_err_d;
    logic       stp_err_q, stp_err_d;
    logic       data_valid_q, data_valid_d;
    logic       exp_par;
    logic       decide;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .edge_cnt    (edge_cnt_q),
        .sampled_bit (sampled_bit)
    );

    assign exp_par = par_typ_q ? ~^P_DATA : ^P_DATA;
    assign decide  = (edge_cnt_q == DECIDE_EDGE);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        data_valid_d = 1'b0;

        if (state_q == ST_IDLE) begin
            edge_cnt_d = 3'd0;
            bit_cnt_d  = START_BIT;
            if (!RX_IN) begin
                // The detect cycle is edge 0 of the start bit.
                state_d    = ST_START;
                edge_cnt_d = 3'd1;
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_err_d  = 1'b0;
                stp_err_d  = 1'b0;
            end
        end else begin
            edge_cnt_d = edge_cnt_q + 3'd1;
            if (decide) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end

        if (decide) begin
            case (state_q)
                ST_START: begin
                    if (sampled_bit) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = START_BIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_err_d = (sampled_bit != exp_par);
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    stp_err_d    = ~sampled_bit;
                    data_valid_d = ~par_err_q & sampled_bit;
                    state_d      = ST_IDLE;
                    bit_cnt_d    = START_BIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= 3'd0;
            bit_cnt_q    <= 4'd0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign edge_cnt   = edge_cnt_q;
    assign bit_cnt    = bit_cnt_q;
    assign deser_en   = (state_q == ST_DATA);
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a behavioural deserializer closes the loop and a
// scoreboard queue holds the bytes expected on each data_valid pulse.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic [2:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit, deser_en, data_valid, par_err, stp_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic dv_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .sampled_bit(sampled_bit), .deser_en(deser_en), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    // External deserializer: LSB first, captures at edge 6 of data bits.
    always @(posedge clk or negedge rst) begin
        if (!rst) P_DATA <= 8'h00;
        else if (deser_en && edge_cnt == 3'd6) P_DATA[bit_cnt[2:0] - 3'd1] <= sampled_bit;
    end

    // Scoreboard monitor: every data_valid pulse pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            dv_prev = 1'b0;
        end else begin
            if (data_valid) begin
                n_tests++;
                if (dv_prev) begin
                    n_fail++;
                    $display("FAIL dv_width: data_valid high 2 cycles, required 1");
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dv_unexpected: data_valid=1 with P_DATA=%h, required no pulse", P_DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (P_DATA !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: P_DATA=%h required %h", P_DATA, e);
                    end
                end
            end
            dv_prev = data_valid;
        end
    end

    function automatic logic good_par(input logic [7:0] d, input logic typ);
        return typ ? ~^d : ^d;
    endfunction

    task automatic send_bit(input logic b, input int inv_edge);
        for (int e = 0; e < 8; e++) begin
            RX_IN = (e == inv_edge) ? ~b : b;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic par_bit, input logic stop_bit,
                              input int inv, input logic flip);
        PAR_EN = pen; PAR_TYP = ptyp;
        send_bit(1'b0, -1);
        if (flip) begin PAR_EN = ~pen; PAR_TYP = ~ptyp; end
        for (int i = 0; i < 8; i++) send_bit(d[i], inv);
        if (pen) send_bit(par_bit, -1);
        send_bit(stop_bit, -1);
        RX_IN = 1'b1; PAR_EN = pen; PAR_TYP = ptyp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(3);
        n_tests++; if (edge_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_edge_cnt: got %0d required 0", edge_cnt); end
        n_tests++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_bit_cnt: got %0d required 0", bit_cnt); end
        n_tests++; if ({sampled_bit, deser_en, data_valid, par_err, stp_err} !== 5'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b required 00000", {sampled_bit, deser_en, data_valid, par_err, stp_err});
        end
        rst = 1'b1;
        idle(4);
        n_tests++; if (edge_cnt !== 3'd0 || bit_cnt !== 4'd0) begin
            n_fail++; $display("FAIL idle_hold: edge=%0d bit=%0d required 0/0", edge_cnt, bit_cnt);
        end
    endtask

    task automatic test_good_parity;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, good_par(8'h55, 1'b0), 1'b1, -1, 1'b0);
        n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL good_dv_latency: data_valid=%b required 1", data_valid); end
        n_tests++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin
            n_fail++; $display("FAIL good_flags: par_err=%b stp_err=%b required 0 0", par_err, stp_err);
        end
        idle(3);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good_pending: %0d bytes left required 0", exp_q.size()); end
    endtask

    task automatic test_glitch;
        logic seen_en;
        seen_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            RX_IN = (i < 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (deser_en) seen_en = 1'b1;
            if (i == 6) begin
                n_tests++; if (edge_cnt !== 3'd7) begin n_fail++; $display("FAIL glitch_edge7: edge_cnt=%0d required 7", edge_cnt); end
            end
            if (i == 7) begin
                n_tests++; if (edge_cnt !== 3'd0 || bit_cnt !== 4'd0) begin
                    n_fail++; $display("FAIL glitch_abort: edge=%0d bit=%0d required 0/0", edge_cnt, bit_cnt);
                end
            end
        end
        n_tests++; if (seen_en !== 1'b0) begin n_fail++; $display("FAIL glitch_deser_en: seen=%b required 0", seen_en); end
        n_tests++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL glitch_idle: bit_cnt=%0d required 0", bit_cnt); end
    endtask

    task automatic test_parity_err;
        send_frame(8'hA3, 1'b1, 1'b1, ~good_par(8'hA3, 1'b1), 1'b1, -1, 1'b0);
        n_tests++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_set: par_err=%b required 1", par_err); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL par_err_dv: data_valid=%b required 0", data_valid); end
        n_tests++; if (P_DATA !== 8'hA3) begin n_fail++; $display("FAIL par_err_data: P_DATA=%h required a3", P_DATA); end
        idle(4);
        n_tests++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_err_hold: par_err=%b required 1", par_err); end
    endtask

    task automatic test_stop_err;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        n_tests++; if (stp_err !== 1'b1) begin n_fail++; $display("FAIL stp_err_set: stp_err=%b required 1", stp_err); end
        n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL stp_par_clear: par_err=%b required 0", par_err); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stp_err_dv: data_valid=%b required 0", data_valid); end
        idle(4);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        n_tests++; if (data_valid !== 1'b1 || stp_err !== 1'b0) begin
            n_fail++; $display("FAIL stp_recover: data_valid=%b stp_err=%b required 1 0", data_valid, stp_err);
        end
        idle(3);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stp_pending: %0d bytes left required 0", exp_q.size()); end
    endtask

    task automatic test_glitch_data;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL vote_dv: data_valid=%b required 1", data_valid); end
        idle(3);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL vote_pending: %0d bytes left required 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d;
        d = 8'h81;
        PAR_EN = 1'b0;
        send_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) send_bit(d[i], -1);
        RX_IN = d[3];
        idle(2);
        n_tests++; if (deser_en !== 1'b1 || bit_cnt !== 4'd4) begin
            n_fail++; $display("FAIL mid_pre: deser_en=%b bit_cnt=%0d required 1 4", deser_en, bit_cnt);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++; if ({edge_cnt, bit_cnt, sampled_bit, deser_en, data_valid, par_err, stp_err, P_DATA} !== 20'h0) begin
            n_fail++; $display("FAIL mid_rst_outputs: edge=%0d bit=%0d flags=%b P_DATA=%h required all 0",
                edge_cnt, bit_cnt, {sampled_bit, deser_en, data_valid, par_err, stp_err}, P_DATA);
        end
        RX_IN = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(3);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, good_par(8'h81, 1'b0), 1'b1, -1, 1'b0);
        n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_recover_dv: data_valid=%b required 1", data_valid); end
        idle(3);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_pending: %0d bytes left required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hC7);
        send_frame(8'h12, 1'b1, 1'b0, good_par(8'h12, 1'b0), 1'b1, -1, 1'b0);
        n_tests++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_dv: data_valid=%b required 1", data_valid); end
        // Second frame flips PAR_EN/PAR_TYP mid-frame; the latched config must hold.
        send_frame(8'hC7, 1'b1, 1'b1, good_par(8'hC7, 1'b1), 1'b1, -1, 1'b1);
        n_tests++; if (data_valid !== 1'b1 || par_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: data_valid=%b par_err=%b required 1 0", data_valid, par_err);
        end
        idle(3);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: %0d bytes left required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_good_parity();
        test_glitch();
        test_parity_err();
        test_stop_err();
        test_glitch_data();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
